// File: rtl/calc2_req_sequencer_if.sv
// Bundle of signals between the request sequencer and its neighbours:
// the operation handshake, the two-cycle calc2 request bus, the calc2
// response bus, and the result/status outputs.
interface calc2_req_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2
);
    logic                    op_valid;
    logic                    op_ready;
    logic [3:0]              op_cmd;
    logic [DATA_W-1:0]       op_a;
    logic [DATA_W-1:0]       op_b;
    logic [3:0]              req_cmd_out;
    logic [DATA_W-1:0]       req_data_out;
    logic [TAG_W-1:0]        req_tag_out;
    logic [1:0]              dut_resp_in;
    logic [DATA_W-1:0]       dut_data_in;
    logic [TAG_W-1:0]        dut_tag_in;
    logic                    res_valid;
    logic [1:0]              res_resp;
    logic [DATA_W-1:0]       res_data;
    logic [TAG_W-1:0]        res_tag;
    logic [(1<<TAG_W)-1:0]   busy_tags;
    logic                    spurious_err;

    // Sequencer side
    modport slave (
        input  op_valid, op_cmd, op_a, op_b,
        input  dut_resp_in, dut_data_in, dut_tag_in,
        output op_ready, req_cmd_out, req_data_out, req_tag_out,
        output res_valid, res_resp, res_data, res_tag, busy_tags, spurious_err
    );

    // Operation source / calc2 side
    modport master (
        output op_valid, op_cmd, op_a, op_b,
        output dut_resp_in, dut_data_in, dut_tag_in,
        input  op_ready, req_cmd_out, req_data_out, req_tag_out,
        input  res_valid, res_resp, res_data, res_tag, busy_tags, spurious_err
    );
endinterface

// File: rtl/calc2_req_sequencer.sv
// Issue stage for one calc2 request port: takes whole operations, tags them,
// serialises them as cmd/op A then op B, and matches responses or timeouts
// back to the outstanding tags.
//
//  state  | meaning
//  IDLE   | request bus idle, may accept an op when a tag is free
//  SEND1  | driving cmd + op A with the allocated tag
//  SEND2  | driving cmd 0 + op B; tag timer starts here
module calc2_req_sequencer #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 2,
    parameter int TIMEOUT = 64
) (
    input logic                  c_clk,
    input logic                  reset,
    calc2_req_sequencer_if.slave bus
);
    localparam int NTAG  = 1 << TAG_W;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND1 = 2'd1;
    localparam logic [1:0] S_SEND2 = 2'd2;

    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    logic [1:0]        state, state_next;
    logic [TAG_W-1:0]  cur_tag;
    logic [DATA_W-1:0] op_b_q;
    logic [NTAG-1:0]   busy, busy_next;
    logic [TMR_W-1:0]  timer [NTAG];

    logic              accept;
    logic              resp_any;
    logic              resp_hit;
    logic              exp_any;
    logic              fire_to;
    logic [TAG_W-1:0]  exp_tag;
    logic [TAG_W-1:0]  alloc_tag;

    assign accept   = bus.op_valid & bus.op_ready;
    assign resp_any = (bus.dut_resp_in != 2'd0);
    assign resp_hit = resp_any & busy[bus.dut_tag_in];
    // A real response owns the result slot; an expired tag waits saturated.
    assign fire_to  = exp_any & ~resp_hit;
    assign bus.busy_tags = busy;

    // Lowest expired tag and lowest free tag (scan downwards so lowest wins).
    always_comb begin
        exp_any   = 1'b0;
        exp_tag   = '0;
        alloc_tag = '0;
        for (int t = NTAG - 1; t >= 0; t--) begin
            if (busy[t] && (timer[t] == TMR_MAX)) begin
                exp_any = 1'b1;
                exp_tag = TAG_W'(t);
            end
            if (!busy[t]) begin
                alloc_tag = TAG_W'(t);
            end
        end
    end

    // Next busy bitmap and next FSM state.
    always_comb begin
        busy_next = busy;
        if (accept) busy_next[alloc_tag] = 1'b1;
        if (resp_hit) busy_next[bus.dut_tag_in] = 1'b0;
        if (fire_to) busy_next[exp_tag] = 1'b0;
        case (state)
            S_IDLE:  state_next = accept ? S_SEND1 : S_IDLE;
            S_SEND1: state_next = S_SEND2;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM, request bus, handshake and result registers.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            cur_tag          <= '0;
            op_b_q           <= '0;
            busy             <= '0;
            bus.op_ready     <= 1'b0;
            bus.req_cmd_out  <= 4'd0;
            bus.req_data_out <= '0;
            bus.req_tag_out  <= '0;
            bus.res_valid    <= 1'b0;
            bus.res_resp     <= 2'd0;
            bus.res_data     <= '0;
            bus.res_tag      <= '0;
            bus.spurious_err <= 1'b0;
        end else begin
            state        <= state_next;
            busy         <= busy_next;
            // Tags freed this edge are visible only from the next edge on.
            bus.op_ready <= (state_next == S_IDLE) && (busy_next != '1);

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur_tag          <= alloc_tag;
                        op_b_q           <= bus.op_b;
                        bus.req_cmd_out  <= bus.op_cmd;
                        bus.req_data_out <= bus.op_a;
                        bus.req_tag_out  <= alloc_tag;
                    end else begin
                        bus.req_cmd_out  <= 4'd0;
                        bus.req_data_out <= '0;
                        bus.req_tag_out  <= '0;
                    end
                end
                S_SEND1: begin
                    bus.req_cmd_out  <= 4'd0;
                    bus.req_data_out <= op_b_q;
                    bus.req_tag_out  <= cur_tag;
                end
                default: begin
                    bus.req_cmd_out  <= 4'd0;
                    bus.req_data_out <= '0;
                    bus.req_tag_out  <= '0;
                end
            endcase

            bus.res_valid    <= resp_hit | fire_to;
            bus.spurious_err <= resp_any & ~resp_hit;
            if (resp_hit) begin
                bus.res_resp <= bus.dut_resp_in;
                bus.res_data <= bus.dut_data_in;
                bus.res_tag  <= bus.dut_tag_in;
            end else if (fire_to) begin
                bus.res_resp <= RESP_TIMEOUT;
                bus.res_data <= '0;
                bus.res_tag  <= exp_tag;
            end else begin
                bus.res_resp <= 2'd0;
                bus.res_data <= '0;
                bus.res_tag  <= '0;
            end
        end
    end

    // Per-tag timers: 0 = not running; start at 1 as op B goes out,
    // count up and hold at TIMEOUT until the timeout can be reported.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NTAG; t++) timer[t] <= '0;
        end else begin
            for (int t = 0; t < NTAG; t++) begin
                if ((resp_hit && (bus.dut_tag_in == TAG_W'(t))) ||
                    (fire_to && (exp_tag == TAG_W'(t)))) begin
                    timer[t] <= '0;
                end else if ((state == S_SEND1) && (cur_tag == TAG_W'(t)) && busy[t]) begin
                    timer[t] <= TMR_ONE;
                end else if ((timer[t] != '0) && (timer[t] != TMR_MAX)) begin
                    timer[t] <= timer[t] + TMR_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_calc2_req_sequencer.sv
// Bench for calc2_req_sequencer. Two instances: a long-timeout one for the
// request/response tests and a TIMEOUT=8 one for timeout tests; "sel" routes
// the stimulus and the observed outputs to one of them. Results and spurious
// pulses are checked by a monitor against a scoreboard filled by stimulus.
module tb_calc2_req_sequencer;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 2;
    localparam int SHORT_TO = 8;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    always #5 c_clk = ~c_clk;

    calc2_req_sequencer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus_l ();
    calc2_req_sequencer_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus_s ();

    calc2_req_sequencer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT(64)) dut_l (
        .c_clk(c_clk), .reset(reset), .bus(bus_l));
    calc2_req_sequencer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT(SHORT_TO)) dut_s (
        .c_clk(c_clk), .reset(reset), .bus(bus_s));

    logic        sel;
    logic        op_valid;
    logic [3:0]  op_cmd;
    logic [31:0] op_a, op_b, rsp_data;
    logic [1:0]  rsp, rsp_tag;

    assign bus_l.op_valid    = op_valid & ~sel;
    assign bus_s.op_valid    = op_valid & sel;
    assign bus_l.op_cmd      = op_cmd;
    assign bus_s.op_cmd      = op_cmd;
    assign bus_l.op_a        = op_a;
    assign bus_s.op_a        = op_a;
    assign bus_l.op_b        = op_b;
    assign bus_s.op_b        = op_b;
    assign bus_l.dut_resp_in = sel ? 2'd0 : rsp;
    assign bus_s.dut_resp_in = sel ? rsp : 2'd0;
    assign bus_l.dut_data_in = rsp_data;
    assign bus_s.dut_data_in = rsp_data;
    assign bus_l.dut_tag_in  = rsp_tag;
    assign bus_s.dut_tag_in  = rsp_tag;

    logic        m_op_ready, m_res_valid, m_spurious;
    logic [3:0]  m_req_cmd, m_busy;
    logic [31:0] m_req_data, m_res_data;
    logic [1:0]  m_req_tag, m_res_resp, m_res_tag;

    assign m_op_ready  = sel ? bus_s.op_ready     : bus_l.op_ready;
    assign m_res_valid = sel ? bus_s.res_valid    : bus_l.res_valid;
    assign m_spurious  = sel ? bus_s.spurious_err : bus_l.spurious_err;
    assign m_req_cmd   = sel ? bus_s.req_cmd_out  : bus_l.req_cmd_out;
    assign m_req_data  = sel ? bus_s.req_data_out : bus_l.req_data_out;
    assign m_req_tag   = sel ? bus_s.req_tag_out  : bus_l.req_tag_out;
    assign m_res_resp  = sel ? bus_s.res_resp     : bus_l.res_resp;
    assign m_res_data  = sel ? bus_s.res_data     : bus_l.res_data;
    assign m_res_tag   = sel ? bus_s.res_tag      : bus_l.res_tag;
    assign m_busy      = sel ? bus_s.busy_tags    : bus_l.busy_tags;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        int          cyc;   // posedge count at which the result appears
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_spur = 0;

    always @(posedge c_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Result / spurious monitor
    always @(negedge c_clk) begin
        if (reset) begin
            if (m_res_valid) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got resp=%0d data=0x%0h tag=%0d expected none",
                             m_res_resp, m_res_data, m_res_tag);
                end else begin
                    mon_e = sb.pop_front();
                    check("res_resp", 64'(m_res_resp), 64'(mon_e.resp));
                    check("res_data", 64'(m_res_data), 64'(mon_e.data));
                    check("res_tag", 64'(m_res_tag), 64'(mon_e.tag));
                    check("res_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
            if (m_spurious) begin
                n_total++;
                if (exp_spur > 0) begin
                    exp_spur--;
                    n_pass++;
                end else begin
                    $display("FAIL spurious_err: got pulse expected none (t=%0t)", $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    // Wait for op_ready, then offer one op; returns just after the accept edge.
    task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!m_op_ready && n < 40) begin
            tick();
            n++;
        end
        check("op_ready_wait", 64'(m_op_ready), 64'd1);
        op_valid = 1'b1; op_cmd = c; op_a = a; op_b = b;
        tick();
        // Junk after accept: the sequencer must use its captured copies.
        op_valid = 1'b0; op_cmd = 4'hF; op_a = 32'hDEAD_BEEF; op_b = 32'hCAFE_F00D;
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] tag, output int s2);
        start_op(c, a, b);
        check("send1_cmd", 64'(m_req_cmd), 64'(c));
        check("send1_data", 64'(m_req_data), 64'(a));
        check("send1_tag", 64'(m_req_tag), 64'(tag));
        tick();
        s2 = cyc;
        check("send2_cmd", 64'(m_req_cmd), 64'd0);
        check("send2_data", 64'(m_req_data), 64'(b));
        check("send2_tag", 64'(m_req_tag), 64'(tag));
        tick();
        check("idle_req", {m_req_cmd, m_req_tag, m_req_data}, 64'd0);
    endtask

    task automatic respond(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t,
                           input bit hit);
        if (hit) sb.push_back('{resp: r, data: d, tag: t, cyc: cyc + 1});
        else exp_spur++;
        rsp = r; rsp_data = d; rsp_tag = t;
        tick();
        rsp = 2'd0; rsp_data = 32'd0; rsp_tag = 2'd0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s2, s2a, s2b, n;
        sel = 1'b0; op_valid = 1'b0; op_cmd = 4'd0; op_a = 32'd0; op_b = 32'd0;
        rsp = 2'd0; rsp_data = 32'd0; rsp_tag = 2'd0;
        reset = 1'b0;
        repeat (2) @(posedge c_clk);
        #1;
        check("rst_op_ready", 64'(m_op_ready), 64'd0);
        check("rst_busy", 64'(m_busy), 64'd0);
        check("rst_res_valid", 64'(m_res_valid), 64'd0);
        reset = 1'b1;
        tick();
        check("op_ready_after_release", 64'(m_op_ready), 64'd1);

        // Subtract: cmd/op A then op B on tag 0, response returned as result
        issue(4'd2, 32'h22, 32'h3, 2'd0, s2);
        check("busy_one_op", 64'(m_busy), 64'h1);
        respond(2'd1, 32'h1F, 2'd0, 1'b1);
        check("busy_after_resp", 64'(m_busy), 64'h0);

        // Reset asserted in the middle of SEND1
        start_op(4'd1, 32'h10, 32'h20);
        check("pre_reset_cmd", 64'(m_req_cmd), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_req", {m_req_cmd, m_req_tag, m_req_data}, 64'd0);
        check("mid_rst_busy", 64'(m_busy), 64'd0);
        check("mid_rst_res", {m_res_valid, m_res_resp, m_res_tag, m_res_data}, 64'd0);
        check("mid_rst_op_ready", 64'(m_op_ready), 64'd0);
        @(posedge c_clk);
        #2;
        reset = 1'b1;
        tick();
        check("op_ready_after_mid_rst", 64'(m_op_ready), 64'd1);

        // Fill the tag pool, free tag 2, reallocate it
        issue(4'd1, 32'h100, 32'h1, 2'd0, s2);
        issue(4'd5, 32'h200, 32'h2, 2'd1, s2);
        issue(4'd6, 32'h300, 32'h3, 2'd2, s2);
        issue(4'd9, 32'h400, 32'h4, 2'd3, s2);
        check("busy_full", 64'(m_busy), 64'hF);
        check("op_ready_full", 64'(m_op_ready), 64'd0);
        respond(2'd1, 32'hAA, 2'd2, 1'b1);
        check("busy_tag2_freed", 64'(m_busy), 64'hB);
        check("op_ready_tag_free", 64'(m_op_ready), 64'd1);
        issue(4'd2, 32'h50, 32'h10, 2'd2, s2);
        check("busy_refull", 64'(m_busy), 64'hF);
        respond(2'd2, 32'h11, 2'd0, 1'b1);
        respond(2'd1, 32'h22, 2'd1, 1'b1);
        respond(2'd1, 32'h33, 2'd2, 1'b1);
        respond(2'd1, 32'h44, 2'd3, 1'b1);
        check("busy_emptied", 64'(m_busy), 64'h0);

        // Response on a tag that is not outstanding
        issue(4'd1, 32'h1, 32'h2, 2'd0, s2);
        check("busy_0001", 64'(m_busy), 64'h1);
        respond(2'd1, 32'h5, 2'd2, 1'b0);
        check("busy_after_spurious", 64'(m_busy), 64'h1);
        respond(2'd1, 32'h3, 2'd0, 1'b1);
        drain();

        // Timeout tests on the TIMEOUT=8 instance
        sel = 1'b1;
        tick();
        issue(4'd1, 32'h7, 32'h9, 2'd0, s2);
        sb.push_back('{resp: 2'd3, data: 32'd0, tag: 2'd0, cyc: s2 + SHORT_TO});
        drain();
        check("busy_after_timeout", 64'(m_busy), 64'h0);
        respond(2'd1, 32'h99, 2'd0, 1'b0);
        check("busy_after_late_resp", 64'(m_busy), 64'h0);

        // Tag 1 response lands on the edge where tag 0 would time out
        issue(4'd1, 32'h1, 32'h1, 2'd0, s2a);
        issue(4'd2, 32'h8, 32'h2, 2'd1, s2b);
        n = 0;
        while (cyc < s2a + SHORT_TO - 1 && n < 50) begin
            tick();
            n++;
        end
        check("reach_collision_cycle", 64'(cyc), 64'(s2a + SHORT_TO - 1));
        respond(2'd1, 32'h42, 2'd1, 1'b1);
        sb.push_back('{resp: 2'd3, data: 32'd0, tag: 2'd0, cyc: s2a + SHORT_TO + 1});
        drain();
        check("busy_after_collision", 64'(m_busy), 64'h0);

        repeat (3) tick();
        check("spurious_pending", 64'(exp_spur), 64'd0);
        check("busy_long_inst_idle", 64'(bus_l.busy_tags), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
